// File: rtl/paddle_pkg.sv
// Shared pong constants and the paddle FSM state encoding.
// Used by paddle and btn_debounce.
package paddle_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        PADDLE_IDLE = 2'd0,
        PADDLE_UP   = 2'd1,
        PADDLE_DOWN = 2'd2
    } paddle_state_e;

    // Exactly one button selects a direction; none or both mean stand still.
    function automatic paddle_state_e next_dir(input logic up, input logic down);
        paddle_state_e dir;
        case ({up, down})
            2'b10:   dir = PADDLE_UP;
            2'b01:   dir = PADDLE_DOWN;
            default: dir = PADDLE_IDLE;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/paddle_btn_debounce.sv
// Button conditioning: 2-FF synchronizer followed by a debounce counter.
// The level flips only after 2**DEBOUNCE_BITS consecutive differing cycles.
module btn_debounce
    import paddle_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic                     level_q, level_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    // Synchronizer stages and debounce counter next-state.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == {DEBOUNCE_BITS{1'b1}}) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                level_d = level_q;
                cnt_d   = cnt_q + {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};
            end
        end else begin
            level_d = level_q;
            cnt_d   = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/paddle.sv
// Player paddle: per-frame movement FSM, position clamp and registered hit test.
// Optional macro PADDLE_ACCEL_EN enables the speed ramp; otherwise speed is SPEED_MAX.
module paddle #(
    parameter int X_POS         = 16,
    parameter int WIDTH         = 8,
    parameter int HEIGHT        = 80,
    parameter int V_ACTIVE      = paddle_pkg::V_ACTIVE,
    parameter int SPEED_MAX     = 8,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        vblank,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic        pixel_valid,
    output logic [10:0] paddle_top
);

    import paddle_pkg::*;

    localparam int                 SPW      = $clog2(SPEED_MAX + 1);
    localparam logic [10:0]        TOP_RST  = 11'((V_ACTIVE - HEIGHT) / 2);
    localparam logic signed [11:0] LIMIT_S  = 12'(V_ACTIVE - HEIGHT);
    localparam logic [SPW-1:0]     SPEED_MX = SPW'(SPEED_MAX);

    logic          up_lvl_s, down_lvl_s;
    logic          vblank_q, vblank_d;
    logic          tick_q, tick_d;
    paddle_state_e state_q, state_d;
    logic [10:0]   top_q, top_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [SPW-1:0] speed_move_s;
    logic signed [11:0] top_ext_s, step_s, up_pos_s, down_pos_s;
    logic          h_in_s, v_in_s;

    btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_up (
        .clk(clk), .rst(rst), .btn(btn_up), .level(up_lvl_s)
    );

    btn_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_down (
        .clk(clk), .rst(rst), .btn(btn_down), .level(down_lvl_s)
    );

`ifdef PADDLE_ACCEL_EN
    logic [SPW-1:0] speed_q, speed_d;

    // Speed ramp: restarts at 1 on entry or reversal, saturates at SPEED_MAX.
    always_comb begin
        speed_d = speed_q;
        if (tick_q) begin
            case (state_d)
                PADDLE_UP, PADDLE_DOWN: begin
                    if (state_d != state_q) begin
                        speed_d = {{(SPW-1){1'b0}}, 1'b1};
                    end else if (speed_q >= SPEED_MX) begin
                        speed_d = SPEED_MX;
                    end else begin
                        speed_d = speed_q + {{(SPW-1){1'b0}}, 1'b1};
                    end
                end
                default: speed_d = '0;
            endcase
        end else begin
            speed_d = speed_q;
        end
        speed_move_s = speed_d;
    end

    // Speed register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q <= '0;
        end else begin
            speed_q <= speed_d;
        end
    end
`else
    // Constant speed whenever a direction is selected.
    always_comb begin
        speed_move_s = '0;
        if (state_d == PADDLE_IDLE) begin
            speed_move_s = '0;
        end else begin
            speed_move_s = SPEED_MX;
        end
    end
`endif

    // Frame tick, direction FSM and clamped position update.
    always_comb begin
        vblank_d   = vblank;
        tick_d     = vblank & ~vblank_q;
        state_d    = state_q;
        top_d      = top_q;
        top_ext_s  = $signed({1'b0, top_q});
        step_s     = $signed(12'(speed_move_s));
        up_pos_s   = top_ext_s - step_s;
        down_pos_s = top_ext_s + step_s;
        if (tick_q) begin
            state_d = next_dir(up_lvl_s, down_lvl_s);
            case (state_d)
                PADDLE_UP: begin
                    if (up_pos_s < 12'sd0) begin
                        top_d = 11'd0;
                    end else begin
                        top_d = up_pos_s[10:0];
                    end
                end
                PADDLE_DOWN: begin
                    if (down_pos_s > LIMIT_S) begin
                        top_d = LIMIT_S[10:0];
                    end else begin
                        top_d = down_pos_s[10:0];
                    end
                end
                default: top_d = top_q;
            endcase
        end else begin
            state_d = state_q;
            top_d   = top_q;
        end
    end

    // Hit test against the current pixel; registered for one cycle of latency.
    always_comb begin
        h_in_s = ({1'b0, hcount} >= 12'(X_POS)) && ({1'b0, hcount} < 12'(X_POS + WIDTH));
        v_in_s = ({1'b0, vcount} >= {1'b0, top_q}) &&
                 ({1'b0, vcount} < ({1'b0, top_q} + 12'(HEIGHT)));
        if (h_in_s && v_in_s) begin
            pixel_valid_d = 1'b1;
        end else begin
            pixel_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank_q      <= 1'b0;
            tick_q        <= 1'b0;
            state_q       <= PADDLE_IDLE;
            top_q         <= TOP_RST;
            pixel_valid_q <= 1'b0;
        end else begin
            vblank_q      <= vblank_d;
            tick_q        <= tick_d;
            state_q       <= state_d;
            top_q         <= top_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign paddle_top  = top_q;

endmodule
